// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and default operand width.
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_e;

endpackage

// File: rtl/FullAdder.sv
// Single-bit full-adder cell; the only arithmetic in the serial datapath.
module FullAdder (
  input  logic A,
  input  logic B,
  input  logic C_in,
  output logic S,
  output logic C_out
);

  assign S     = A ^ B ^ C_in;
  assign C_out = (A & B) | (C_in & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds A + B + C_in LSB first, one bit per clk, through one FullAdder cell.
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit per cycle, WIDTH cycles
// DONE  | result just written to S/C_out, done high; start here chains the next add
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q, s_q;
  logic [WIDTH-1:0] sum_shift;
  logic             carry_q, cout_q;
  logic [CW-1:0]    cnt_q;
  logic             fa_s, fa_c;
  logic             last_bit;

  FullAdder u_fa (
    .A     (a_q[0]),
    .B     (b_q[0]),
    .C_in  (carry_q),
    .S     (fa_s),
    .C_out (fa_c)
  );

  assign last_bit = (cnt_q == LAST);

  // Written as shift-then-patch so WIDTH=1 needs no zero-width slice.
  always_comb begin
    sum_shift            = sum_q >> 1;
    sum_shift[WIDTH-1]   = fa_s;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= C_in;
            cnt_q   <= '0;
          end
        end
        ST_RUN: begin
          sum_q   <= sum_shift;
          carry_q <= fa_c;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) begin
            s_q    <= sum_shift;
            cout_q <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign S     = s_q;
  assign C_out = cout_q;

endmodule
